// File: rtl/ddr_phy_pkg.sv
// Shared DDR PHY fabric definitions: delay-line sequencer states and phase-word constants.
package ddr_phy_pkg;

  localparam int unsigned PHASE_W        = 4;
  localparam logic        IDLE_LEVEL_DEF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MOVE,
    ST_SETTLE,
    ST_DONE
  } adj_state_t;

endpackage

// File: rtl/ddr3_cmd_pin_ctrl_if.sv
// Fabric/IOD signal bundle for one DDR3 command pin controller.
interface ddr3_cmd_pin_ctrl_if #(
  parameter int unsigned TAP_W = 8
);
  import ddr_phy_pkg::*;

  logic                 CMD_VALID;
  logic [PHASE_W-1:0]   CMD_PHASE;
  logic [1:0]           CMD_LAT;
  logic                 OE_REQ;
  logic [PHASE_W-1:0]   TX_DATA_0;
  logic [PHASE_W-1:0]   OE_DATA_0;
  logic                 ADJ_REQ;
  logic                 ADJ_DIR;
  logic [TAP_W-1:0]     ADJ_STEPS;
  logic                 ADJ_LOAD;
  logic                 ADJ_BUSY;
  logic                 ADJ_DONE;
  logic                 ADJ_ERR;
  logic [TAP_W-1:0]     ADJ_COUNT;
  logic                 DELAY_LINE_MOVE_0;
  logic                 DELAY_LINE_DIRECTION_0;
  logic                 DELAY_LINE_LOAD_0;
  logic                 DELAY_LINE_OUT_OF_RANGE_0;

  modport master (
    output CMD_VALID, CMD_PHASE, CMD_LAT, OE_REQ,
    output ADJ_REQ, ADJ_DIR, ADJ_STEPS, ADJ_LOAD,
    output DELAY_LINE_OUT_OF_RANGE_0,
    input  TX_DATA_0, OE_DATA_0,
    input  ADJ_BUSY, ADJ_DONE, ADJ_ERR, ADJ_COUNT,
    input  DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0
  );

  modport slave (
    input  CMD_VALID, CMD_PHASE, CMD_LAT, OE_REQ,
    input  ADJ_REQ, ADJ_DIR, ADJ_STEPS, ADJ_LOAD,
    input  DELAY_LINE_OUT_OF_RANGE_0,
    output TX_DATA_0, OE_DATA_0,
    output ADJ_BUSY, ADJ_DONE, ADJ_ERR, ADJ_COUNT,
    output DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0
  );

endinterface

// File: rtl/ddr_dly_step_seq.sv
// IOD dynamic delay-line step/reload sequencer with post-pulse settle counter.
module ddr_dly_step_seq
  import ddr_phy_pkg::*;
#(
  parameter int unsigned TAP_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_dir,
  input  logic [TAP_W-1:0] i_steps,
  input  logic             i_load,
  input  logic             i_oor,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [TAP_W-1:0] o_count,
  output logic             o_move,
  output logic             o_dir,
  output logic             o_load
);

  localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  adj_state_t       r_state, w_next;
  logic [TAP_W-1:0] r_remaining, r_count;
  logic [CNT_W-1:0] r_settle_cnt;
  logic             r_err, r_dir, r_load_flag;
  logic             r_busy, r_done, r_move, r_load;
  logic             w_settle_last, w_settle_exit;

  assign w_settle_last = (r_settle_cnt == CNT_LAST);
  assign w_settle_exit = r_load_flag || i_oor || (r_remaining == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load)     w_next = ST_LOAD;
        else if (i_req) w_next = (i_steps == '0) ? ST_DONE : ST_MOVE;
      end
      ST_LOAD, ST_MOVE: w_next = ST_SETTLE;
      ST_SETTLE: if (w_settle_last) w_next = w_settle_exit ? ST_DONE : ST_MOVE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Pin-facing strobes are registered from the current state, so they trail the
  // state by one cycle and the latched direction leads the first MOVE pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_remaining  <= '0;
      r_count      <= '0;
      r_settle_cnt <= '0;
      r_err        <= 1'b0;
      r_dir        <= 1'b0;
      r_load_flag  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_move       <= 1'b0;
      r_load       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_count     <= '0;
            r_err       <= 1'b0;
            r_load_flag <= 1'b1;
          end else if (i_req) begin
            r_dir       <= i_dir;
            r_remaining <= i_steps;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_load_flag <= 1'b0;
          end
        end
        ST_LOAD: r_settle_cnt <= '0;
        ST_MOVE: begin
          r_settle_cnt <= '0;
          r_remaining  <= r_remaining - 1'b1;
          if (r_count != '1) r_count <= r_count + 1'b1;
        end
        ST_SETTLE: begin
          if (!w_settle_last) r_settle_cnt <= r_settle_cnt + 1'b1;
          else if (i_oor)     r_err        <= 1'b1;
        end
        default: ;
      endcase
      r_busy <= (r_state != ST_IDLE);
      r_done <= (r_state == ST_DONE);
      r_move <= (r_state == ST_MOVE);
      r_load <= (r_state == ST_LOAD);
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_err   = r_err;
  assign o_count = r_count;
  assign o_move  = r_move;
  assign o_dir   = r_dir;
  assign o_load  = r_load;

endmodule

// File: rtl/ddr3_cmd_pin_ctrl.sv
// DDR3 command pin fabric driver: latency-aligned 4-phase TX/OE words plus delay-line sequencing.
module ddr3_cmd_pin_ctrl
  import ddr_phy_pkg::*;
#(
  parameter int unsigned TAP_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic        IDLE_LEVEL    = IDLE_LEVEL_DEF,
  parameter int unsigned LAT_MAX       = 3
) (
  input  logic                FAB_CLK,
  input  logic                RESET_N,
  ddr3_cmd_pin_ctrl_if.slave  bus
);

  localparam logic [PHASE_W-1:0] IDLE_WORD = {PHASE_W{IDLE_LEVEL}};

  logic [PHASE_W-1:0] r_word [0:LAT_MAX];
  logic [LAT_MAX:0]   r_oe;
  logic [PHASE_W-1:0] r_tx;
  logic               r_oe_out;
  logic [1:0]         w_tap;

  assign w_tap = (32'(bus.CMD_LAT) > LAT_MAX) ? 2'(LAT_MAX) : bus.CMD_LAT;

  // Output register after the tap mux gives the 1+CMD_LAT edge latency.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i <= LAT_MAX; i++) r_word[i] <= IDLE_WORD;
      r_oe     <= '0;
      r_tx     <= IDLE_WORD;
      r_oe_out <= 1'b0;
    end else begin
      r_word[0] <= bus.CMD_VALID ? bus.CMD_PHASE : IDLE_WORD;
      for (int unsigned i = 1; i <= LAT_MAX; i++) r_word[i] <= r_word[i-1];
      r_oe     <= {r_oe[LAT_MAX-1:0], bus.OE_REQ};
      r_tx     <= r_word[w_tap];
      r_oe_out <= r_oe[w_tap];
    end
  end

  assign bus.TX_DATA_0 = r_tx;
  assign bus.OE_DATA_0 = {PHASE_W{r_oe_out}};

  ddr_dly_step_seq #(
    .TAP_W         (TAP_W),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_seq (
    .i_clk   (FAB_CLK),
    .i_rst_n (RESET_N),
    .i_req   (bus.ADJ_REQ),
    .i_dir   (bus.ADJ_DIR),
    .i_steps (bus.ADJ_STEPS),
    .i_load  (bus.ADJ_LOAD),
    .i_oor   (bus.DELAY_LINE_OUT_OF_RANGE_0),
    .o_busy  (bus.ADJ_BUSY),
    .o_done  (bus.ADJ_DONE),
    .o_err   (bus.ADJ_ERR),
    .o_count (bus.ADJ_COUNT),
    .o_move  (bus.DELAY_LINE_MOVE_0),
    .o_dir   (bus.DELAY_LINE_DIRECTION_0),
    .o_load  (bus.DELAY_LINE_LOAD_0)
  );

endmodule

// File: tb/tb_ddr3_cmd_pin_ctrl.sv
// Directed self-checking bench for ddr3_cmd_pin_ctrl (SETTLE_CYCLES=4, TAP_W=8).
module tb_ddr3_cmd_pin_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ddr3_cmd_pin_ctrl_if #(.TAP_W(8)) bus ();

  ddr3_cmd_pin_ctrl #(
    .TAP_W         (8),
    .SETTLE_CYCLES (4),
    .IDLE_LEVEL    (1'b1),
    .LAT_MAX       (3)
  ) dut (
    .FAB_CLK (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.TX_DATA_0 !== 4'b1111) begin n_fail++; $display("FAIL reset_tx got %b want 1111", bus.TX_DATA_0); end
    n_checks++; if (bus.OE_DATA_0 !== 4'b0000) begin n_fail++; $display("FAIL reset_oe got %b want 0000", bus.OE_DATA_0); end
    n_checks++; if (bus.ADJ_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.ADJ_BUSY); end
    n_checks++; if (bus.ADJ_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.ADJ_DONE); end
    n_checks++; if (bus.ADJ_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.ADJ_ERR); end
    n_checks++; if (bus.ADJ_COUNT !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.ADJ_COUNT); end
    n_checks++; if (bus.DELAY_LINE_MOVE_0 !== 1'b0) begin n_fail++; $display("FAIL reset_move got %b want 0", bus.DELAY_LINE_MOVE_0); end
    n_checks++; if (bus.DELAY_LINE_LOAD_0 !== 1'b0) begin n_fail++; $display("FAIL reset_load got %b want 0", bus.DELAY_LINE_LOAD_0); end
    n_checks++; if (bus.DELAY_LINE_DIRECTION_0 !== 1'b0) begin n_fail++; $display("FAIL reset_dir got %b want 0", bus.DELAY_LINE_DIRECTION_0); end
  endtask

  // One command word with OE_REQ, sampled at edge N; expected at c == 1+lat only.
  task automatic test_latency(input logic [1:0] lat, input logic [3:0] pat);
    logic [3:0] exp_tx, exp_oe;
    bus.CMD_LAT   = lat;
    step();
    step();
    bus.CMD_VALID = 1'b1;
    bus.CMD_PHASE = pat;
    bus.OE_REQ    = 1'b1;
    step();
    bus.CMD_VALID = 1'b0;
    bus.CMD_PHASE = 4'b0000;
    bus.OE_REQ    = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      exp_tx = (c == 32'(lat) + 1) ? pat : 4'b1111;
      exp_oe = (c == 32'(lat) + 1) ? 4'b1111 : 4'b0000;
      n_checks++; if (bus.TX_DATA_0 !== exp_tx) begin n_fail++; $display("FAIL lat%0d_tx c=%0d got %b want %b", lat, c, bus.TX_DATA_0, exp_tx); end
      n_checks++; if (bus.OE_DATA_0 !== exp_oe) begin n_fail++; $display("FAIL lat%0d_oe c=%0d got %b want %b", lat, c, bus.OE_DATA_0, exp_oe); end
      step();
    end
  endtask

  task automatic test_step_seq();
    logic exp_move, exp_done, exp_busy;
    bus.ADJ_REQ = 1'b1; bus.ADJ_DIR = 1'b1; bus.ADJ_STEPS = 8'd3;
    step();
    bus.ADJ_REQ = 1'b0; bus.ADJ_STEPS = 8'd0; bus.ADJ_DIR = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      exp_move = (c == 1) || (c == 6) || (c == 11);
      exp_done = (c == 16);
      exp_busy = (c >= 1) && (c <= 16);
      n_checks++; if (bus.DELAY_LINE_MOVE_0 !== exp_move) begin n_fail++; $display("FAIL seq_move c=%0d got %b want %b", c, bus.DELAY_LINE_MOVE_0, exp_move); end
      n_checks++; if (bus.ADJ_DONE !== exp_done) begin n_fail++; $display("FAIL seq_done c=%0d got %b want %b", c, bus.ADJ_DONE, exp_done); end
      n_checks++; if (bus.ADJ_BUSY !== exp_busy) begin n_fail++; $display("FAIL seq_busy c=%0d got %b want %b", c, bus.ADJ_BUSY, exp_busy); end
      if (c >= 0 && c <= 1) begin
        n_checks++; if (bus.DELAY_LINE_DIRECTION_0 !== 1'b1) begin n_fail++; $display("FAIL seq_dir c=%0d got %b want 1", c, bus.DELAY_LINE_DIRECTION_0); end
      end
      step();
    end
    n_checks++; if (bus.ADJ_COUNT !== 8'd3) begin n_fail++; $display("FAIL seq_count got %0d want 3", bus.ADJ_COUNT); end
    n_checks++; if (bus.ADJ_ERR !== 1'b0) begin n_fail++; $display("FAIL seq_err got %b want 0", bus.ADJ_ERR); end
  endtask

  task automatic test_out_of_range();
    logic exp_move, exp_done, exp_busy;
    bus.ADJ_REQ = 1'b1; bus.ADJ_DIR = 1'b0; bus.ADJ_STEPS = 8'd10;
    step();
    bus.ADJ_REQ = 1'b0; bus.ADJ_STEPS = 8'd0;
    for (int c = 0; c <= 16; c++) begin
      exp_move = (c == 1) || (c == 6);
      exp_done = (c == 11);
      exp_busy = (c >= 1) && (c <= 11);
      n_checks++; if (bus.DELAY_LINE_MOVE_0 !== exp_move) begin n_fail++; $display("FAIL oor_move c=%0d got %b want %b", c, bus.DELAY_LINE_MOVE_0, exp_move); end
      n_checks++; if (bus.ADJ_DONE !== exp_done) begin n_fail++; $display("FAIL oor_done c=%0d got %b want %b", c, bus.ADJ_DONE, exp_done); end
      n_checks++; if (bus.ADJ_BUSY !== exp_busy) begin n_fail++; $display("FAIL oor_busy c=%0d got %b want %b", c, bus.ADJ_BUSY, exp_busy); end
      if (c == 6) bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
      step();
    end
    bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    n_checks++; if (bus.ADJ_COUNT !== 8'd2) begin n_fail++; $display("FAIL oor_count got %0d want 2", bus.ADJ_COUNT); end
    n_checks++; if (bus.ADJ_ERR !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b want 1", bus.ADJ_ERR); end
    n_checks++; if (bus.DELAY_LINE_DIRECTION_0 !== 1'b0) begin n_fail++; $display("FAIL oor_dir got %b want 0", bus.DELAY_LINE_DIRECTION_0); end
  endtask

  task automatic test_load_priority();
    logic exp_load, exp_done, exp_busy;
    bus.ADJ_LOAD = 1'b1; bus.ADJ_REQ = 1'b1; bus.ADJ_DIR = 1'b1; bus.ADJ_STEPS = 8'd5;
    step();
    bus.ADJ_LOAD = 1'b0; bus.ADJ_REQ = 1'b0; bus.ADJ_STEPS = 8'd0;
    for (int c = 0; c <= 12; c++) begin
      exp_load = (c == 1);
      exp_done = (c == 6);
      exp_busy = (c >= 1) && (c <= 6);
      n_checks++; if (bus.DELAY_LINE_LOAD_0 !== exp_load) begin n_fail++; $display("FAIL ld_load c=%0d got %b want %b", c, bus.DELAY_LINE_LOAD_0, exp_load); end
      n_checks++; if (bus.DELAY_LINE_MOVE_0 !== 1'b0) begin n_fail++; $display("FAIL ld_move c=%0d got %b want 0", c, bus.DELAY_LINE_MOVE_0); end
      n_checks++; if (bus.ADJ_DONE !== exp_done) begin n_fail++; $display("FAIL ld_done c=%0d got %b want %b", c, bus.ADJ_DONE, exp_done); end
      n_checks++; if (bus.ADJ_BUSY !== exp_busy) begin n_fail++; $display("FAIL ld_busy c=%0d got %b want %b", c, bus.ADJ_BUSY, exp_busy); end
      if (c == 3) begin bus.ADJ_REQ = 1'b1; bus.ADJ_STEPS = 8'd2; end
      if (c == 4) begin bus.ADJ_REQ = 1'b0; bus.ADJ_STEPS = 8'd0; end
      step();
    end
    n_checks++; if (bus.ADJ_COUNT !== 8'd0) begin n_fail++; $display("FAIL ld_count got %0d want 0", bus.ADJ_COUNT); end
    n_checks++; if (bus.ADJ_ERR !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b want 0", bus.ADJ_ERR); end
  endtask

  task automatic test_zero_steps();
    bus.ADJ_REQ = 1'b1; bus.ADJ_STEPS = 8'd0;
    step();
    bus.ADJ_REQ = 1'b0;
    step();
    n_checks++; if (bus.ADJ_DONE !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", bus.ADJ_DONE); end
    n_checks++; if (bus.DELAY_LINE_MOVE_0 !== 1'b0) begin n_fail++; $display("FAIL zero_move got %b want 0", bus.DELAY_LINE_MOVE_0); end
    step();
    n_checks++; if (bus.ADJ_BUSY !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", bus.ADJ_BUSY); end
  endtask

  task automatic test_reset_mid_sequence();
    bus.ADJ_REQ = 1'b1; bus.ADJ_DIR = 1'b1; bus.ADJ_STEPS = 8'd3;
    step();
    bus.ADJ_REQ = 1'b0; bus.ADJ_STEPS = 8'd0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    n_checks++; if (bus.ADJ_BUSY !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", bus.ADJ_BUSY); end
    n_checks++; if (bus.ADJ_COUNT !== 8'd0) begin n_fail++; $display("FAIL rmid_count got %0d want 0", bus.ADJ_COUNT); end
    n_checks++; if (bus.DELAY_LINE_DIRECTION_0 !== 1'b0) begin n_fail++; $display("FAIL rmid_dir got %b want 0", bus.DELAY_LINE_DIRECTION_0); end
    n_checks++; if (bus.DELAY_LINE_MOVE_0 !== 1'b0) begin n_fail++; $display("FAIL rmid_move got %b want 0", bus.DELAY_LINE_MOVE_0); end
    n_checks++; if (bus.TX_DATA_0 !== 4'b1111) begin n_fail++; $display("FAIL rmid_tx got %b want 1111", bus.TX_DATA_0); end
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      n_checks++; if (bus.ADJ_DONE !== 1'b0) begin n_fail++; $display("FAIL rmid_done c=%0d got %b want 0", c, bus.ADJ_DONE); end
      n_checks++; if (bus.DELAY_LINE_MOVE_0 !== 1'b0) begin n_fail++; $display("FAIL rmid_move2 c=%0d got %b want 0", c, bus.DELAY_LINE_MOVE_0); end
    end
  endtask

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_PHASE = 4'b0000;
    bus.CMD_LAT   = 2'd0;
    bus.OE_REQ    = 1'b0;
    bus.ADJ_REQ   = 1'b0;
    bus.ADJ_DIR   = 1'b0;
    bus.ADJ_STEPS = 8'd0;
    bus.ADJ_LOAD  = 1'b0;
    bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;

    test_reset();
    test_latency(2'd2, 4'b1110);
    test_latency(2'd0, 4'b0101);
    test_latency(2'd3, 4'b0011);
    test_step_seq();
    test_out_of_range();
    test_load_priority();
    test_zero_steps();
    test_reset_mid_sequence();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_cmd_pin_ctrl.md
# ddr3_cmd_pin_ctrl

Fabric-side driver for one DDR3 command pin (CAS_N, RAS_N, WE_N class) on PolarFire. It sits directly upstream of the pin's IOD wrapper. It turns per-FAB_CLK command requests into the 4-phase TX_DATA_0/OE_DATA_0 words, with a programmable alignment latency. It also sequences the IOD dynamic delay line: step, reload, settle and out-of-range handling.

## Interface
- TAP_W, 8, width of step request/count
- SETTLE_CYCLES, 4, FAB_CLK cycles held after each MOVE/LOAD pulse before next action (≥1)
- IDLE_LEVEL, 1'b1, pin level driven when no command (active-low command pins idle high)
- LAT_MAX, 3, maximum extra alignment delay; CMD_LAT width fixed at 2
- FAB_CLK  in  1  sole clock; all logic rising-edge
- RESET_N  in  1  synchronous, active-low reset
- CMD_VALID  in  1  command present this cycle
- CMD_PHASE  in  4  pin level per phase, bit0 earliest in time
- CMD_LAT  in  2  extra alignment delay in FAB_CLK cycles (0..LAT_MAX), quasi-static
- OE_REQ  in  1  enable output driver
- TX_DATA_0  out  4  to IOD TX_DATA_0
- OE_DATA_0  out  4  to IOD OE_DATA_0
- ADJ_REQ  in  1  start delay-line step sequence (single-cycle pulse)
- ADJ_DIR  in  1  step direction, sampled with ADJ_REQ
- ADJ_STEPS  in  TAP_W  number of taps, sampled with ADJ_REQ
- ADJ_LOAD  in  1  reload delay line to its static value (pulse)
- ADJ_BUSY  out  1  sequencer not IDLE
- ADJ_DONE  out  1  one-cycle completion pulse
- ADJ_ERR  out  1  last sequence stopped on out-of-range; sticky until next accepted request
- ADJ_COUNT  out  TAP_W  taps actually moved in last/current sequence
- DELAY_LINE_MOVE_0  out  1  to IOD
- DELAY_LINE_DIRECTION_0  out  1  to IOD
- DELAY_LINE_LOAD_0  out  1  to IOD
- DELAY_LINE_OUT_OF_RANGE_0  in  1  from IOD

## Operation
- Data path: each cycle, word = CMD_VALID ? CMD_PHASE : {4{IDLE_LEVEL}}; oe = OE_REQ. Both enter a shift pipeline of depth 1+LAT_MAX. Output tap = stage 1+CMD_LAT. OE_DATA_0 = {4{oe at that tap}}.
- CMD_LAT changes only while idle. On a change, output is taken from the new tap immediately. No flush.
- Sequencer FSM states: IDLE, LOAD, MOVE, SETTLE, DONE.
- IDLE: if ADJ_LOAD=1 -> LOAD, and ADJ_COUNT<=0, ADJ_ERR<=0. Else if ADJ_REQ=1, latch dir/steps, ADJ_COUNT<=0, ADJ_ERR<=0. Then steps==0 -> DONE, else -> MOVE. ADJ_LOAD has priority over a same-cycle ADJ_REQ.
- LOAD: DELAY_LINE_LOAD_0=1 for one cycle -> SETTLE (load flag set).
- MOVE: DELAY_LINE_MOVE_0=1 for one cycle. ADJ_COUNT+1; remaining-1 -> SETTLE.
- SETTLE: counts SETTLE_CYCLES. On the last cycle, go to DONE if load flag, OUT_OF_RANGE=1 (then ADJ_ERR<=1), or remaining==0. Else -> MOVE.
- DONE: ADJ_DONE=1 for one cycle -> IDLE.
- DELAY_LINE_DIRECTION_0 holds the latched direction from acceptance until the next acceptance. It is stable ≥1 cycle before the first MOVE.
- ADJ_REQ/ADJ_LOAD outside IDLE are ignored (not queued).
- ADJ_COUNT saturates; it never wraps (ADJ_STEPS ≤ 2^TAP_W−1 bounds it).

## Timing
- Reset (RESET_N=0 at edge) sets all pipeline stages to {IDLE_LEVEL}, oe=0. Outputs: TX_DATA_0={4{IDLE_LEVEL}}, OE_DATA_0=0, MOVE/LOAD=0, DIRECTION=0, ADJ_BUSY=0, ADJ_DONE=0, ADJ_ERR=0, ADJ_COUNT=0, FSM=IDLE.
- Reset mid-sequence aborts immediately. No DONE pulse; MOVE/LOAD deassert on the next edge.
- Data latency: input at edge N appears on TX_DATA_0 after edge N+1+CMD_LAT.
- Sequence of S>0 steps, no error: ADJ_REQ accepted at edge N. MOVE pulses at cycles N+1+k·(1+SETTLE_CYCLES). ADJ_DONE at N+1+S·(1+SETTLE_CYCLES). ADJ_BUSY high from N+1 through the DONE cycle.
- ADJ_STEPS=0: ADJ_DONE in cycle N+1, no MOVE.
- All outputs are registered.

## Structure
- Shared package ddr_phy_pkg holds the FSM state enum (adj_state_t), the IDLE_LEVEL default, and the phase-word width constant (4).
- One sub-module: ddr_dly_step_seq (the sequencer FSM plus settle counter), reusable by the DQ/DQS lane controllers. The latency pipeline stays inline.

## Test plan
- Reset then idle: TX_DATA_0=4'b1111, OE_DATA_0=4'b0000, ADJ_BUSY=0.
- CMD_LAT=2, OE_REQ=1, one CMD_VALID with CMD_PHASE=4'b1110 at edge N -> TX_DATA_0=4'b1110 and OE_DATA_0=4'b1111 after edge N+3 only; 4'b1111 otherwise.
- ADJ_REQ, DIR=1, STEPS=3, SETTLE_CYCLES=4 -> MOVE pulses at N+1, N+6, N+11; ADJ_DONE at N+16; ADJ_COUNT=3; ADJ_ERR=0.
- STEPS=10 with OUT_OF_RANGE forced high after the 2nd MOVE -> DONE after the 2nd settle; ADJ_COUNT=2; ADJ_ERR=1.
- ADJ_LOAD and ADJ_REQ in the same cycle -> a single LOAD pulse, no MOVE; DONE after 1+SETTLE_CYCLES; ADJ_REQ during BUSY is ignored.
- RESET_N low during SETTLE -> all outputs return to reset values next edge, no ADJ_DONE pulse.
